// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-datapath sequencer:
// opcodes, register select codes, ALU op codes and FSM states.
package ctrl_pkg;

    localparam int INST_W = 32;
    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_MC  = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b101;
    localparam logic [2:0] OP_MR  = 3'b110;
    localparam logic [2:0] OP_MW  = 3'b111;

    localparam logic [1:0] REG_A    = 2'b00;
    localparam logic [1:0] REG_B    = 2'b01;
    localparam logic [1:0] REG_ACC  = 2'b10;
    localparam logic [1:0] REG_ZERO = 2'b11;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_CLEAR,
        ST_HALT
    } state_t;

    // A destination code with the upper bit set always means the accumulator.
    function automatic logic [1:0] dst_to_waddr(input logic [1:0] dst);
        return dst[1] ? REG_ACC : dst;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: splits the instruction register into
// its fields and classifies the opcode.
module seq_decode
    import ctrl_pkg::*;
(
    input  logic [INST_W-1:0] ir,
    output logic [1:0]        src,
    output logic [1:0]        dst,
    output logic [24:0]       imm,
    output logic              is_alu,
    output logic              is_div,
    output logic              is_mr,
    output logic              is_mw,
    output logic              is_mc,
    output logic              is_hlt,
    output logic [3:0]        alu_op
);

    logic [2:0] op;

    assign op  = ir[31:29];
    assign src = ir[28:27];
    assign dst = ir[26:25];
    assign imm = ir[24:0];

    assign is_div = (op == OP_DIV);

    // Classify the opcode and pick the matching ALU function.
    always_comb begin
        is_alu = 1'b0;
        is_mr  = 1'b0;
        is_mw  = 1'b0;
        is_mc  = 1'b0;
        is_hlt = 1'b0;
        alu_op = ALU_NOP;
        case (op)
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_DIV: begin is_alu = 1'b1; alu_op = ALU_DIV; end
            OP_MUL: begin is_alu = 1'b1; alu_op = ALU_MUL; end
            OP_MC:  is_mc  = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            OP_MR:  is_mr  = 1'b1;
            OP_MW:  is_mw  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_control.sv
// Multi-cycle sequencer for the accumulator datapath. Fetches one
// instruction at a time and steps the register bank, ALU and data memory.
// Data outputs are held in registers so they keep their last driven value
// between the cycles in which the FSM actively drives them.
module seq_control
    import ctrl_pkg::*;
#(
    parameter int PC_W      = 4,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic              inst_req,
    output logic [PC_W-1:0]   inst_addr,
    input  logic              inst_ack,
    input  logic [INST_W-1:0] inst,
    output logic [1:0]        rb_raddr1,
    output logic [1:0]        rb_raddr2,
    input  logic [DATA_W-1:0] rb_rdata1,
    input  logic [DATA_W-1:0] rb_rdata2,
    output logic              rb_we,
    output logic [1:0]        rb_waddr,
    output logic [DATA_W-1:0] rb_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(MEM_DEPTH - 1);

    state_t state;
    state_t state_next;

    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] cnt;
    logic              err_q;

    logic [1:0]        raddr1_q;
    logic [1:0]        raddr2_q;
    logic [1:0]        waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [1:0]  dec_src;
    logic [1:0]  dec_dst;
    logic [24:0] dec_imm;
    logic        dec_is_alu;
    logic        dec_is_div;
    logic        dec_is_mr;
    logic        dec_is_mw;
    logic        dec_is_mc;
    logic        dec_is_hlt;
    logic [3:0]  dec_alu_op;
    logic        div_zero;
    logic        unused_imm;

    seq_decode u_decode (
        .ir     (ir),
        .src    (dec_src),
        .dst    (dec_dst),
        .imm    (dec_imm),
        .is_alu (dec_is_alu),
        .is_div (dec_is_div),
        .is_mr  (dec_is_mr),
        .is_mw  (dec_is_mw),
        .is_mc  (dec_is_mc),
        .is_hlt (dec_is_hlt),
        .alu_op (dec_alu_op)
    );

    assign div_zero   = dec_is_div && (op_b == '0);
    assign unused_imm = ^dec_imm[24:ADDR_W];

    // State register; reset drops straight back to IDLE, aborting any clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic: one step of the instruction per cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  if (inst_ack) state_next = ST_DECODE;
            ST_DECODE: begin
                if (dec_is_alu)      state_next = ST_EXEC;
                else if (dec_is_mr)  state_next = ST_MEM_RD;
                else if (dec_is_mw)  state_next = ST_MEM_WR;
                else if (dec_is_mc)  state_next = ST_CLEAR;
                else if (dec_is_hlt) state_next = ST_HALT;
            end
            ST_EXEC:   state_next = div_zero ? ST_HALT : ST_FETCH;
            ST_MEM_RD: state_next = ST_MEM_WB;
            ST_MEM_WB: state_next = ST_FETCH;
            ST_MEM_WR: state_next = ST_FETCH;
            ST_CLEAR:  if (cnt == CNT_LAST) state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Program counter, instruction register, operand latches, clear counter and error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc    <= '0;
            ir    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) pc <= '0;
                ST_FETCH: begin
                    if (inst_ack) begin
                        ir <= inst;
                        pc <= pc + 1'b1;
                    end
                end
                ST_DECODE: begin
                    op_a <= rb_rdata1;
                    op_b <= (dec_src == REG_ZERO) ? '0 : rb_rdata2;
                    cnt  <= '0;
                end
                ST_EXEC:  if (div_zero) err_q <= 1'b1;
                ST_CLEAR: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Output logic: strobes default low, data outputs default to their held value.
    always_comb begin
        inst_req  = 1'b0;
        rb_we     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        rb_raddr1 = raddr1_q;
        rb_raddr2 = raddr2_q;
        rb_waddr  = waddr_q;
        rb_wdata  = wdata_q;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        alu_op    = alu_op_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        case (state)
            ST_FETCH: inst_req = 1'b1;
            ST_DECODE: begin
                rb_raddr1 = REG_ACC;
                rb_raddr2 = dec_src;
            end
            ST_EXEC: begin
                alu_a  = op_a;
                alu_b  = op_b;
                alu_op = dec_alu_op;
                if (!div_zero) begin
                    rb_we    = 1'b1;
                    rb_waddr = REG_ACC;
                    rb_wdata = alu_res;
                end
            end
            ST_MEM_RD: begin
                mem_en   = 1'b1;
                mem_addr = dec_imm[ADDR_W-1:0];
            end
            ST_MEM_WB: begin
                rb_we    = 1'b1;
                rb_waddr = dst_to_waddr(dec_dst);
                rb_wdata = mem_rdata;
            end
            ST_MEM_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dec_imm[ADDR_W-1:0];
                mem_wdata = op_b;
            end
            ST_CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

    // Capture whatever the data outputs showed this cycle so they hold afterwards.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            raddr1_q    <= rb_raddr1;
            raddr2_q    <= rb_raddr2;
            waddr_q     <= rb_waddr;
            wdata_q     <= rb_wdata;
            alu_a_q     <= alu_a;
            alu_b_q     <= alu_b;
            alu_op_q    <= alu_op;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    assign inst_addr = pc;
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign halted    = (state == ST_HALT);
    assign err       = err_q;

endmodule
